multicycle_control: RTL

MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

---
 rtl/cpu_pkg.sv | 44 ++++
 rtl/opcode_decode.sv | 31 +++
 rtl/multicycle_control.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the multicycle CPU control path.
//   state_e     : control FSM states
//   ins_class_e : instruction classes produced by opcode_decode
//   OP_*        : opcode field constants (ins[31:21], or its upper bits)
//   ALUOP_*     : encodings sent to alu_control_unit
package cpu_pkg;

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC_R,
    S_WB_R,
    S_ADDR,
    S_MEM_RD,
    S_WB_LD,
    S_MEM_WR,
    S_BR_CBZ,
    S_BR_B,
    S_HALT
  } state_e;

  typedef enum logic [2:0] {
    CLS_RTYPE,
    CLS_LDUR,
    CLS_STUR,
    CLS_CBZ,
    CLS_B,
    CLS_ILLEGAL
  } ins_class_e;

  localparam logic [10:0] OP_ADD  = 11'b10001011000;
  localparam logic [10:0] OP_SUB  = 11'b11001011000;
  localparam logic [10:0] OP_AND  = 11'b10001010000;
  localparam logic [10:0] OP_ORR  = 11'b10101010000;
  localparam logic [10:0] OP_LDUR = 11'b11111000010;
  localparam logic [10:0] OP_STUR = 11'b11111000000;
  localparam logic [7:0]  OP_CBZ  = 8'b10110100;   // matched against ins[31:24]
  localparam logic [5:0]  OP_B    = 6'b000101;     // matched against ins[31:26]

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_PASSB = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

endpackage

// File: rtl/opcode_decode.sv
// Combinational opcode classifier.
//   opcode_i : ins[31:21]
//   cls_o    : instruction class (ins_class_e encoding)
module opcode_decode
  import cpu_pkg::*;
(
  input  logic [10:0] opcode_i,
  output logic [2:0]  cls_o
);

  ins_class_e cls;

  always_comb begin
    cls = CLS_ILLEGAL;
    if (opcode_i == OP_ADD || opcode_i == OP_SUB ||
        opcode_i == OP_AND || opcode_i == OP_ORR) begin
      cls = CLS_RTYPE;
    end else if (opcode_i == OP_LDUR) begin
      cls = CLS_LDUR;
    end else if (opcode_i == OP_STUR) begin
      cls = CLS_STUR;
    end else if (opcode_i[10:3] == OP_CBZ) begin
      cls = CLS_CBZ;
    end else if (opcode_i[10:5] == OP_B) begin
      cls = CLS_B;
    end
  end

  assign cls_o = cls;

endmodule

// File: rtl/multicycle_control.sv
// Multicycle CPU control FSM.
//   clk, rst   : clock, synchronous active-high reset
//   ins        : instruction register contents (ins[31:21] decoded)
//   zero       : ALU zero flag (used in the CBZ state)
//   mem_ack    : memory completion for the outstanding request
//   mem_req/mem_we, ir_write, pc_write, pc_src, reg_write, mem_to_reg,
//   reg2loc, alusrc, aluop : datapath controls for the current state
//   retire     : one-cycle pulse per completed instruction
//   illegal    : high while halted on an undecodable opcode
module multicycle_control
  import cpu_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] ins,
  input  logic        zero,
  input  logic        mem_ack,
  output logic        mem_req,
  output logic        mem_we,
  output logic        ir_write,
  output logic        pc_write,
  output logic        pc_src,
  output logic        reg_write,
  output logic        mem_to_reg,
  output logic        reg2loc,
  output logic        alusrc,
  output logic [1:0]  aluop,
  output logic        retire,
  output logic        illegal
);

  state_e     state_q, state_d;
  ins_class_e cls;
  logic [2:0] cls_raw;

  // Only the opcode field matters; the operand bits are intentionally dropped.
  logic unused_ins_bits;
  assign unused_ins_bits = ^ins[20:0];

  opcode_decode u_opcode_decode (
    .opcode_i (ins[31:21]),
    .cls_o    (cls_raw)
  );

  assign cls = ins_class_e'(cls_raw);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  // Outputs are gated off while rst is high so an interrupted request
  // (e.g. mid MEM_WR) never shows during the reset cycle.
  always_comb begin
    state_d    = state_q;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    pc_src     = 1'b0;
    reg_write  = 1'b0;
    mem_to_reg = 1'b0;
    reg2loc    = 1'b0;
    alusrc     = 1'b0;
    aluop      = ALUOP_ADD;
    retire     = 1'b0;
    illegal    = 1'b0;
    if (!rst) begin
      case (state_q)
        S_FETCH: begin
          mem_req = 1'b1;
          if (mem_ack) begin
            ir_write = 1'b1;
            pc_write = 1'b1;
            state_d  = S_DECODE;
          end
        end
        S_DECODE: begin
          case (cls)
            CLS_RTYPE:          state_d = S_EXEC_R;
            CLS_LDUR, CLS_STUR: state_d = S_ADDR;
            CLS_CBZ:            state_d = S_BR_CBZ;
            CLS_B:              state_d = S_BR_B;
            default:            state_d = S_HALT;
          endcase
        end
        S_EXEC_R: begin
          aluop   = ALUOP_FUNCT;
          state_d = S_WB_R;
        end
        S_WB_R: begin
          reg_write = 1'b1;
          aluop     = ALUOP_FUNCT;
          retire    = 1'b1;
          state_d   = S_FETCH;
        end
        S_ADDR: begin
          alusrc  = 1'b1;
          state_d = (cls == CLS_STUR) ? S_MEM_WR : S_MEM_RD;
        end
        S_MEM_RD: begin
          mem_req = 1'b1;
          alusrc  = 1'b1;
          if (mem_ack) state_d = S_WB_LD;
        end
        S_WB_LD: begin
          reg_write  = 1'b1;
          mem_to_reg = 1'b1;
          retire     = 1'b1;
          state_d    = S_FETCH;
        end
        S_MEM_WR: begin
          mem_req = 1'b1;
          mem_we  = 1'b1;
          reg2loc = 1'b1;
          alusrc  = 1'b1;
          if (mem_ack) begin
            retire  = 1'b1;
            state_d = S_FETCH;
          end
        end
        S_BR_CBZ: begin
          aluop    = ALUOP_PASSB;
          reg2loc  = 1'b1;
          pc_src   = 1'b1;
          pc_write = zero;
          retire   = 1'b1;
          state_d  = S_FETCH;
        end
        S_BR_B: begin
          pc_write = 1'b1;
          pc_src   = 1'b1;
          retire   = 1'b1;
          state_d  = S_FETCH;
        end
        S_HALT: begin
          illegal = 1'b1;
        end
        default: state_d = S_FETCH;
      endcase
    end
  end

endmodule
